// File: rtl/axil_to_mcl_n_if.sv
// AXI-Lite slave channel bundle for the axil_to_mcl_n bridge.
// The slave modport is the bridge side; master is the bus-driver side.
interface axil_to_mcl_n_if;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axil_to_mcl_n.sv
// AXI-Lite register bridge to num_chan_p MCL channel pairs: per channel a TX FIFO
// filled by 32-bit word writes and an RX FIFO drained by 32-bit word reads.
module axil_to_mcl_n #(
  parameter int num_chan_p   = 4,
  parameter int fifo_width_p = 128,
  parameter int tx_depth_p   = 8,
  parameter int rx_depth_p   = 8
) (
  input  logic                               clk_i,
  input  logic                               reset_n_i,
  axil_to_mcl_n_if.slave                     s_axil,
  input  logic [num_chan_p-1:0]              mcl_v_i,
  input  logic [num_chan_p*fifo_width_p-1:0] mcl_data_i,
  output logic [num_chan_p-1:0]              mcl_yumi_o,
  output logic [num_chan_p-1:0]              mcl_v_o,
  output logic [num_chan_p*fifo_width_p-1:0] mcl_data_o,
  input  logic [num_chan_p-1:0]              mcl_ready_i
);
  localparam int W   = fifo_width_p / 32;
  localparam int KW  = (W > 1) ? $clog2(W) : 1;
  localparam int TAW = $clog2(tx_depth_p);
  localparam int RAW = $clog2(rx_depth_p);
  localparam int TCW = TAW + 1;
  localparam int RCW = RAW + 1;
  localparam logic [KW-1:0] KLAST = KW'(W - 1);

  localparam logic [7:0] OFF_TXD  = 8'h00;
  localparam logic [7:0] OFF_VAC  = 8'h04;
  localparam logic [7:0] OFF_OCC  = 8'h08;
  localparam logic [7:0] OFF_RXD  = 8'h0C;
  localparam logic [7:0] OFF_CTRL = 8'h10;

  typedef enum logic [1:0] {IDLE, WRESP, RRESP} state_e;

  state_e state_q, state_d;
  logic   wr_acc, rd_acc;

  logic [1:0]  bresp_q, bresp_d, rresp_q, rresp_d;
  logic [31:0] rdata_q, rdata_d;

  logic [3:0] w_ch, r_ch;
  logic [7:0] w_off, r_off;

  logic [num_chan_p-1:0] tx_push, flush, k_adv, j_adv, tx_full;
  logic [fifo_width_p-1:0] tx_elem;

  logic [TCW-1:0]          tx_cnt_w  [num_chan_p];
  logic [RCW-1:0]          rx_cnt_w  [num_chan_p];
  logic [KW-1:0]           k_w       [num_chan_p];
  logic [KW-1:0]           j_w       [num_chan_p];
  logic [fifo_width_p-1:0] asm_w     [num_chan_p];
  logic [fifo_width_p-1:0] rx_head_w [num_chan_p];

  logic unused_addr;
  assign unused_addr = ^{s_axil.awaddr[31:12], s_axil.araddr[31:12]};

  assign w_ch  = s_axil.awaddr[11:8];
  assign w_off = s_axil.awaddr[7:0];
  assign r_ch  = s_axil.araddr[11:8];
  assign r_off = s_axil.araddr[7:0];

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Writes win a same-cycle collision with a read; only one transaction in flight.
  always_comb begin
    state_d = state_q;
    wr_acc  = 1'b0;
    rd_acc  = 1'b0;
    case (state_q)
      IDLE: begin
        wr_acc = reset_n_i & s_axil.awvalid & s_axil.wvalid;
        rd_acc = reset_n_i & s_axil.arvalid & ~wr_acc;
        if (wr_acc)      state_d = WRESP;
        else if (rd_acc) state_d = RRESP;
      end
      WRESP:   if (s_axil.bready) state_d = IDLE;
      RRESP:   if (s_axil.rready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign s_axil.awready = wr_acc;
  assign s_axil.wready  = wr_acc;
  assign s_axil.arready = rd_acc;
  assign s_axil.bvalid  = (state_q == WRESP);
  assign s_axil.rvalid  = (state_q == RRESP);
  assign s_axil.bresp   = bresp_q;
  assign s_axil.rresp   = rresp_q;
  assign s_axil.rdata   = rdata_q;

  always_comb begin
    tx_push = '0;
    flush   = '0;
    k_adv   = '0;
    j_adv   = '0;
    tx_elem = '0;
    bresp_d = 2'b11;
    rresp_d = 2'b11;
    rdata_d = '0;
    for (int c = 0; c < num_chan_p; c++) begin
      if (w_ch == 4'(c)) begin
        bresp_d = 2'b00;
        case (w_off)
          OFF_TXD: begin
            if (s_axil.wstrb != 4'hF) begin
              bresp_d = 2'b10;
            end else begin
              k_adv[c] = wr_acc;
              tx_elem  = asm_w[c];
              tx_elem[{k_w[c], 5'd0} +: 32] = s_axil.wdata;
              // A full FIFO drops the completed element but the word index still wraps.
              if (k_w[c] == KLAST) begin
                if (tx_full[c]) bresp_d = 2'b10;
                else            tx_push[c] = wr_acc;
              end
            end
          end
          OFF_CTRL: flush[c] = wr_acc & s_axil.wdata[0];
          default:  bresp_d = 2'b10;
        endcase
      end
      if (r_ch == 4'(c)) begin
        rresp_d = 2'b00;
        case (r_off)
          OFF_VAC: rdata_d = 32'(tx_depth_p) - 32'(tx_cnt_w[c]);
          OFF_OCC: rdata_d = 32'(rx_cnt_w[c]);
          OFF_RXD: begin
            if (rx_cnt_w[c] == '0) begin
              rresp_d = 2'b10;
            end else begin
              rdata_d  = rx_head_w[c][{j_w[c], 5'd0} +: 32];
              j_adv[c] = rd_acc;
            end
          end
          default: rresp_d = 2'b10;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      bresp_q <= 2'b00;
      rresp_q <= 2'b00;
      rdata_q <= '0;
    end else begin
      if (wr_acc) bresp_q <= bresp_d;
      if (rd_acc) begin
        rresp_q <= rresp_d;
        rdata_q <= rdata_d;
      end
    end
  end

  for (genvar c = 0; c < num_chan_p; c++) begin : g_ch
    logic [fifo_width_p-1:0] tx_mem_q [tx_depth_p];
    logic [fifo_width_p-1:0] rx_mem_q [rx_depth_p];
    logic [fifo_width_p-1:0] asm_q;
    logic [TAW-1:0]          tx_wr_q, tx_rd_q;
    logic [RAW-1:0]          rx_wr_q, rx_rd_q;
    logic [TCW-1:0]          tx_cnt_q;
    logic [RCW-1:0]          rx_cnt_q;
    logic [KW-1:0]           k_q, j_q;
    logic                    tx_deq, rx_enq, rx_deq, rx_full;

    assign tx_full[c] = (tx_cnt_q == TCW'(tx_depth_p));
    assign rx_full    = (rx_cnt_q == RCW'(rx_depth_p));
    assign tx_deq     = mcl_v_o[c] & mcl_ready_i[c];
    assign rx_enq     = mcl_yumi_o[c];
    assign rx_deq     = j_adv[c] & (j_q == KLAST);

    assign mcl_v_o[c]    = reset_n_i & (tx_cnt_q != '0);
    assign mcl_yumi_o[c] = reset_n_i & mcl_v_i[c] & ~rx_full & ~flush[c];
    assign mcl_data_o[c*fifo_width_p +: fifo_width_p] = reset_n_i ? tx_mem_q[tx_rd_q] : '0;

    assign tx_cnt_w[c]  = tx_cnt_q;
    assign rx_cnt_w[c]  = rx_cnt_q;
    assign k_w[c]       = k_q;
    assign j_w[c]       = j_q;
    assign asm_w[c]     = asm_q;
    assign rx_head_w[c] = rx_mem_q[rx_rd_q];

    // Flush shares the reset path so it overrides any same-cycle MCL traffic.
    always_ff @(posedge clk_i) begin
      if (!reset_n_i || flush[c]) begin
        tx_wr_q  <= '0;
        tx_rd_q  <= '0;
        tx_cnt_q <= '0;
        rx_wr_q  <= '0;
        rx_rd_q  <= '0;
        rx_cnt_q <= '0;
        k_q      <= '0;
        j_q      <= '0;
      end else begin
        if (tx_push[c]) tx_wr_q <= tx_wr_q + TAW'(1);
        if (tx_deq)     tx_rd_q <= tx_rd_q + TAW'(1);
        tx_cnt_q <= tx_cnt_q + TCW'(tx_push[c]) - TCW'(tx_deq);
        if (rx_enq)     rx_wr_q <= rx_wr_q + RAW'(1);
        if (rx_deq)     rx_rd_q <= rx_rd_q + RAW'(1);
        rx_cnt_q <= rx_cnt_q + RCW'(rx_enq) - RCW'(rx_deq);
        if (k_adv[c])   k_q <= (k_q == KLAST) ? '0 : k_q + KW'(1);
        if (j_adv[c])   j_q <= (j_q == KLAST) ? '0 : j_q + KW'(1);
      end
    end

    always_ff @(posedge clk_i) begin
      if (tx_push[c]) tx_mem_q[tx_wr_q] <= tx_elem;
      if (rx_enq)     rx_mem_q[rx_wr_q] <= mcl_data_i[c*fifo_width_p +: fifo_width_p];
      if (k_adv[c])   asm_q <= tx_elem;
    end
  end
endmodule
